// File: rtl/fp_mul_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_round_pack
// Purpose  : Back end of the FP multiplier. Takes the raw significand product,
//            normalises it, rounds to nearest-even and packs an IEEE-754 half
//            or single result with exception flags {NV, OF, UF, NX, ZR}.
//            Three pipeline stages share a single enable derived from the
//            output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_round_pack #(
    parameter int LATENCY = 3,
    parameter bit FTZ     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [47:0] MANT,
    input  logic [8:0]  EXP,
    input  logic        SIGN,
    input  logic [4:0]  FLAGS_IN,
    input  logic        MODE_FP,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] RESULT,
    output logic [4:0]  FLAGS_OUT
);

    // Stage valid bits: [0] normalise, [1] round, [LATENCY-1] packed output
    logic [LATENCY-1:0] vld;
    logic               adv;

    assign adv       = ~vld[LATENCY-1] | OUT_READY;
    assign IN_READY  = adv;
    assign OUT_VALID = vld[LATENCY-1];

    // Stage 1 (normalise) signals
    logic               n_h;
    logic signed [9:0]  n_exp;
    logic [22:0]        n_frac;
    logic               n_guard;
    logic               n_sticky;

    logic               s1_sign, s1_mode, s1_nan, s1_inf;
    logic signed [9:0]  s1_exp;
    logic [22:0]        s1_frac;
    logic               s1_guard, s1_sticky;

    // Stage 2 (round) signals
    logic               r_up;
    logic [23:0]        r_inc;
    logic               r_carry;
    logic [22:0]        r_frac;
    logic signed [9:0]  r_exp;

    logic               s2_sign, s2_mode, s2_nan, s2_inf, s2_nx;
    logic signed [9:0]  s2_exp;
    logic [22:0]        s2_frac;

    // Stage 3 (pack) signals
    logic signed [9:0]  p_max;
    logic [31:0]        p_inf, p_zero, p_res;
    logic [4:0]         p_flags;

    // Normalise: pick the leading one position, slice fraction/guard/sticky
    always_comb begin
        n_h   = MANT[47];
        // Codes 384..511 are negative; sign-extending to 10 bits is {EXP[8]&EXP[7], EXP}
        n_exp = $signed({EXP[8] & EXP[7], EXP}) + $signed({9'b0, n_h});
        if (MODE_FP) begin
            if (n_h) begin
                n_frac   = MANT[46:24];
                n_guard  = MANT[23];
                n_sticky = |MANT[22:0];
            end else begin
                n_frac   = MANT[45:23];
                n_guard  = MANT[22];
                n_sticky = |MANT[21:0];
            end
        end else begin
            if (n_h) begin
                n_frac   = {13'b0, MANT[46:37]};
                n_guard  = MANT[36];
                n_sticky = |MANT[35:0];
            end else begin
                n_frac   = {13'b0, MANT[45:36]};
                n_guard  = MANT[35];
                n_sticky = |MANT[34:0];
            end
        end
    end

    // Round to nearest-even; a fraction carry-out bumps the exponent
    always_comb begin
        r_up    = s1_guard & (s1_sticky | s1_frac[0]);
        r_inc   = {1'b0, s1_frac} + {23'b0, r_up};
        r_carry = s1_mode ? r_inc[23] : r_inc[10];
        r_frac  = r_carry ? 23'b0 : r_inc[22:0];
        r_exp   = s1_exp + $signed({9'b0, r_carry});
    end

    // Pack with exception priority: NaN, Inf input, overflow, underflow, normal
    always_comb begin
        p_max   = s2_mode ? 10'sd254 : 10'sd30;
        p_inf   = s2_mode ? {s2_sign, 31'h7F80_0000} : {16'h0, s2_sign, 15'h7C00};
        p_zero  = s2_mode ? {s2_sign, 31'h0} : {16'h0, s2_sign, 15'h0};
        p_res   = 32'h0;
        p_flags = 5'b0;
        if (s2_nan) begin
            p_res   = s2_mode ? 32'h7FC0_0000 : 32'h0000_7E00;
            p_flags = 5'b10000;
        end else if (s2_inf) begin
            p_res   = p_inf;
            p_flags = 5'b00000;
        end else if (s2_exp > p_max) begin
            p_res   = p_inf;
            p_flags = 5'b01010;
        end else if (FTZ && (s2_exp < 10'sd1)) begin
            p_res   = p_zero;
            p_flags = 5'b00111;
        end else begin
            p_res   = s2_mode ? {s2_sign, s2_exp[7:0], s2_frac}
                              : {16'h0, s2_sign, s2_exp[4:0], s2_frac[9:0]};
            p_flags = {3'b000, s2_nx, 1'b0};
        end
    end

    // Valid bits and output registers; reset drops every in-flight beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld       <= '0;
            RESULT    <= 32'h0;
            FLAGS_OUT <= 5'h0;
        end else if (adv) begin
            vld <= {vld[LATENCY-2:0], IN_VALID};
            if (vld[1]) begin
                RESULT    <= p_res;
                FLAGS_OUT <= p_flags;
            end
        end
    end

    // Datapath stage registers; contents are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign   <= SIGN;
            s1_mode   <= MODE_FP;
            s1_nan    <= (FLAGS_IN == 5'b00001);
            s1_inf    <= (FLAGS_IN == 5'b11111);
            s1_exp    <= n_exp;
            s1_frac   <= n_frac;
            s1_guard  <= n_guard;
            s1_sticky <= n_sticky;

            s2_sign   <= s1_sign;
            s2_mode   <= s1_mode;
            s2_nan    <= s1_nan;
            s2_inf    <= s1_inf;
            s2_exp    <= r_exp;
            s2_frac   <= r_frac;
            s2_nx     <= s1_guard | s1_sticky;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_round_pack
// Purpose  : Self-checking bench for fp_mul_round_pack. An integer-arithmetic
//            rounding model feeds an expected-result queue; a compare process
//            checks every cycle the output is valid. Directed vectors carry
//            hand-computed literals that pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IN_VALID;
    logic        IN_READY;
    logic [47:0] MANT;
    logic [8:0]  EXP;
    logic        SIGN;
    logic [4:0]  FLAGS_IN;
    logic        MODE_FP;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic [4:0]  FLAGS_OUT;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   received = 0;
    logic rand_rdy = 1'b0;
    logic rdy_val  = 1'b1;

    fp_mul_round_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .MANT      (MANT),
        .EXP       (EXP),
        .SIGN      (SIGN),
        .FLAGS_IN  (FLAGS_IN),
        .MODE_FP   (MODE_FP),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .FLAGS_OUT (FLAGS_OUT)
    );

    always #5 clk = ~clk;

    // Reference: exact integer rounding of the product, returns {flags, result}
    function automatic logic [36:0] model(input logic md, input logic [47:0] m,
                                          input logic [8:0] ex, input logic s,
                                          input logic [4:0] fi);
        int          e, fb, sh, maxe;
        longint      mv, q, rem, halfv;
        logic [31:0] inf_w, zero_w, eb, fr;
        logic        up;
        fb     = md ? 23 : 10;
        maxe   = md ? 254 : 30;
        inf_w  = md ? {s, 31'h7F80_0000} : {16'h0, s, 15'h7C00};
        zero_w = md ? {s, 31'h0} : {16'h0, s, 15'h0};
        if (fi == 5'b00001) return {5'b10000, (md ? 32'h7FC0_0000 : 32'h0000_7E00)};
        if (fi == 5'b11111) return {5'b00000, inf_w};
        e  = (ex >= 9'd384) ? int'(ex) - 512 : int'(ex);
        mv = longint'({16'h0, m});
        sh = (m[47] ? 47 : 46) - fb;
        if (m[47]) e = e + 1;
        q     = mv >> sh;
        rem   = mv & ((longint'(1) << sh) - 1);
        halfv = longint'(1) << (sh - 1);
        up    = (rem > halfv) || ((rem == halfv) && (q % 2 == 1));
        q     = q + (up ? 1 : 0);
        if (q == (longint'(1) << (fb + 1))) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e > maxe) return {5'b01010, inf_w};
        if (e < 1)    return {5'b00111, zero_w};
        eb = e;
        fr = 32'(q - (longint'(1) << fb));
        if (md) return {3'b000, (rem != 0), 1'b0, s, eb[7:0], fr[22:0]};
        return {3'b000, (rem != 0), 1'b0, 16'h0, s, eb[4:0], fr[9:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Present one beat, wait for acceptance, queue its model result
    task automatic send(input logic md, input logic [47:0] m, input logic [8:0] e,
                        input logic s, input logic [4:0] fi);
        logic [36:0] r;
        int          n;
        r        = model(md, m, e, s, fi);
        MODE_FP  = md;
        MANT     = m;
        EXP      = e;
        SIGN     = s;
        FLAGS_IN = fi;
        IN_VALID = 1'b1;
        n        = 0;
        @(negedge clk);
        while (IN_READY !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (IN_READY !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=%b required=1", IN_READY);
            IN_VALID = 1'b0;
            return;
        end
        expq.push_back('{res: r[31:0], flg: r[36:32]});
        @(posedge clk);
        #1;
        IN_VALID = 1'b0;
    endtask

    // Directed vector: pin the model to a hand literal, then send it
    task automatic run_vec(input string name, input logic md, input logic [47:0] m,
                           input logic [8:0] e, input logic s, input logic [4:0] fi,
                           input logic [31:0] lit_res, input logic [4:0] lit_flg);
        chk(name, 64'(model(md, m, e, s, fi)), 64'({lit_flg, lit_res}));
        send(md, m, e, s, fi);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expq.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(expq.size()), 64'd0);
    endtask

    // OUT_READY driver: steady value or random toggling, updated just after each edge
    initial begin
        OUT_READY = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            OUT_READY = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Compare process: check the queue head whenever the output is valid
    always @(negedge clk) begin
        if (rst_n === 1'b1 && OUT_VALID === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output actual=%h/%b required=none", RESULT, FLAGS_OUT);
            end else begin
                if (RESULT !== expq[0].res || FLAGS_OUT !== expq[0].flg) begin
                    failures++;
                    $display("FAIL pipe_out actual=%h/%b required=%h/%b",
                             RESULT, FLAGS_OUT, expq[0].res, expq[0].flg);
                end
                if (OUT_READY === 1'b1) begin
                    void'(expq.pop_front());
                    received++;
                end
            end
        end
    end

    initial begin
        int          base;
        logic [63:0] rnd;
        logic [47:0] m;
        logic [4:0]  fi;

        rst_n    = 1'b0;
        IN_VALID = 1'b0;
        MANT     = '0;
        EXP      = '0;
        SIGN     = 1'b0;
        FLAGS_IN = '0;
        MODE_FP  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_result",    64'(RESULT),    64'd0);
        chk("rst_flags",     64'(FLAGS_OUT), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(IN_READY),  64'd1);

        // Latency: result appears on the third edge counting the transfer edge
        run_vec("single_normal", 1'b1, 48'h9000_0000_0000, 9'd127, 1'b0, 5'b00000, 32'h4010_0000, 5'b00000);
        chk("lat_edge1", 64'(OUT_VALID), 64'd0);
        @(posedge clk); #1;
        chk("lat_edge2", 64'(OUT_VALID), 64'd0);
        @(posedge clk); #1;
        chk("lat_edge3", 64'(OUT_VALID), 64'd1);
        drain("drain_latency");

        // Directed vectors, back to back
        run_vec("tie_even",     1'b1, 48'h4000_0040_0000, 9'd127, 1'b0, 5'b00000, 32'h3F80_0000, 5'b00010);
        run_vec("round_up",     1'b1, 48'h4000_00C0_0000, 9'd127, 1'b0, 5'b00000, 32'h3F80_0002, 5'b00010);
        run_vec("overflow",     1'b1, 48'h9000_0000_0000, 9'd254, 1'b0, 5'b00000, 32'h7F80_0000, 5'b01010);
        run_vec("underflow",    1'b1, 48'h4000_0000_0000, 9'h1FF, 1'b1, 5'b00000, 32'h8000_0000, 5'b00111);
        run_vec("half_normal",  1'b0, 48'h9000_0000_0000, 9'd15,  1'b0, 5'b00000, 32'h0000_4080, 5'b00000);
        run_vec("half_nan",     1'b0, 48'h9000_0000_0000, 9'd15,  1'b0, 5'b00001, 32'h0000_7E00, 5'b10000);
        run_vec("carry_to_inf", 1'b1, 48'h7FFF_FFC0_0000, 9'd254, 1'b0, 5'b00000, 32'h7F80_0000, 5'b01010);
        run_vec("carry_normal", 1'b1, 48'h7FFF_FFC0_0000, 9'd127, 1'b0, 5'b00000, 32'h4000_0000, 5'b00010);
        run_vec("min_normal",   1'b1, 48'h4000_0000_0000, 9'd1,   1'b0, 5'b00000, 32'h0080_0000, 5'b00000);
        run_vec("exp_zero",     1'b1, 48'h4000_0000_0000, 9'd0,   1'b0, 5'b00000, 32'h0000_0000, 5'b00111);
        run_vec("half_ovf",     1'b0, 48'h9000_0000_0000, 9'd30,  1'b1, 5'b00000, 32'h0000_FC00, 5'b01010);
        run_vec("inf_in_neg",   1'b1, 48'h4000_0000_0000, 9'd127, 1'b1, 5'b11111, 32'hFF80_0000, 5'b00000);
        run_vec("half_uf_neg",  1'b0, 48'h4000_0000_0000, 9'd400, 1'b1, 5'b00000, 32'h0000_8000, 5'b00111);
        run_vec("half_tie",     1'b0, 48'h4008_0000_0000, 9'd15,  1'b0, 5'b00000, 32'h0000_3C00, 5'b00010);
        run_vec("half_up",      1'b0, 48'h4018_0000_0000, 9'd15,  1'b0, 5'b00000, 32'h0000_3C02, 5'b00010);
        run_vec("ignored_code", 1'b1, 48'h9000_0000_0000, 9'd127, 1'b0, 5'b00010, 32'h4010_0000, 5'b00000);
        drain("drain_directed");

        // Backpressure: output stalls, input stalls, then release in order
        base    = received;
        rdy_val = 1'b0;
        send(1'b1, 48'h9000_0000_0000, 9'd127, 1'b0, 5'b00000);
        send(1'b1, 48'h4000_00C0_0000, 9'd127, 1'b0, 5'b00000);
        send(1'b0, 48'h9000_0000_0000, 9'd15,  1'b1, 5'b00000);
        chk("bp_out_valid", 64'(OUT_VALID), 64'd1);
        chk("bp_in_ready",  64'(IN_READY),  64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_held_valid", 64'(OUT_VALID), 64'd1);
        rdy_val = 1'b1;
        send(1'b1, 48'h4000_0000_0000, 9'h1FF, 1'b1, 5'b00000);
        drain("drain_backpressure");
        chk("bp_count", 64'(received - base), 64'd4);

        // Random beats with random output readiness
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rnd = {$urandom(), $urandom()};
            m   = rnd[47:0];
            if (m[47:46] == 2'b00) m[46] = 1'b1;
            fi  = ($urandom_range(0, 9) == 0) ? 5'b00001 :
                  ($urandom_range(0, 9) == 0) ? 5'b11111 : 5'(($urandom_range(0, 15)) << 1);
            send(1'($urandom_range(0, 1)), m, 9'($urandom_range(0, 511)),
                 1'($urandom_range(0, 1)), fi);
        end
        rand_rdy = 1'b0;
        drain("drain_random");

        // Reset mid-stream discards in-flight beats
        send(1'b1, 48'h9000_0000_0000, 9'd127, 1'b0, 5'b00000);
        send(1'b1, 48'h9000_0000_0000, 9'd100, 1'b0, 5'b00000);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("midrst_result",    64'(RESULT),    64'd0);
        expq.delete();
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_ghost", 64'(OUT_VALID), 64'd0);
        run_vec("post_reset", 1'b1, 48'h9000_0000_0000, 9'd127, 1'b0, 5'b00000, 32'h4010_0000, 5'b00000);
        drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always ends
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
